// File: rtl/wordline_decoder_ctrl.sv
// wordline_decoder_ctrl
//   N-to-2^N word-line decoder with a sequenced access controller for the
//   NAND-latch bitcell array. One request is accepted from IDLE; its address
//   and direction are latched. The controller then steps through SETUP
//   (address settle, no word line), PULSE (one word line plus read or write
//   strobe for PULSE_CYC cycles) and RECOVER (all lines low for RECOV_CYC
//   cycles, with done in the last one) before returning to IDLE.
//
// Parameters
//   ADDR_W     address width; word-line count is 2**ADDR_W
//   PULSE_CYC  cycles the selected word line stays high (1..15)
//   RECOV_CYC  cycles all word lines stay low after the pulse (1..15)
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous reset, active-high
//   req   in   access request, sampled only in IDLE
//   adr   in   row address, latched with req
//   rw    in   1 = write, 0 = read, latched with req
//   busy  out  high from the cycle after acceptance until the return to IDLE
//   wl    out  one-hot word-line bus, bit i selects row i
//   we    out  write strobe, high only in PULSE with latched rw = 1
//   re    out  read strobe, high only in PULSE with latched rw = 0
//   done  out  one-cycle pulse in the final RECOVER cycle
//   ovr   out  sticky overrun flag: req seen while busy, cleared only by rst
//
// Every output is a flop, so all outputs change only on a clk edge or on rst.

module wordline_decoder_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int PULSE_CYC = 2,
  parameter int RECOV_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [ADDR_W-1:0]        adr,
  input  logic                     rw,
  output logic                     busy,
  output logic [(2**ADDR_W)-1:0]   wl,
  output logic                     we,
  output logic                     re,
  output logic                     done,
  output logic                     ovr
);

  localparam int WL_N = 2**ADDR_W;

  // ---------------------------------------------------------------------
  // Elaboration-time parameter range checks
  // ---------------------------------------------------------------------
  if (ADDR_W < 1) begin : g_bad_addr_w
    $error("wordline_decoder_ctrl: ADDR_W must be at least 1");
  end
  if (PULSE_CYC < 1 || PULSE_CYC > 15) begin : g_bad_pulse_cyc
    $error("wordline_decoder_ctrl: PULSE_CYC must be in 1..15");
  end
  if (RECOV_CYC < 1 || RECOV_CYC > 15) begin : g_bad_recov_cyc
    $error("wordline_decoder_ctrl: RECOV_CYC must be in 1..15");
  end

  // Counter load values: the counter runs down to zero in the last cycle
  // of a phase, so it is loaded with the phase length minus one.
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYC - 1);
  localparam logic [3:0] RECOV_LAST = 4'(RECOV_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    RECOVER
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   adr_q;
  logic                rw_q;
  logic [3:0]          cnt_q;
  logic                busy_q;
  logic [WL_N-1:0]     wl_q;
  logic                we_q;
  logic                re_q;
  logic                done_q;
  logic                ovr_q;

  // Decoded row pattern for the latched address; loaded into wl_q when
  // SETUP hands over to PULSE.
  logic [WL_N-1:0]     wl_d;

  always_comb begin
    wl_d        = '0;
    wl_d[adr_q] = 1'b1;
  end

  // ---------------------------------------------------------------------
  // Sequencer with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      rw_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      wl_q    <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // A request arriving while the controller is busy is dropped; only
      // the sticky flag records it.
      if (req && busy_q) begin
        ovr_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (req) begin
            adr_q   <= adr;
            rw_q    <= rw;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end

        SETUP: begin
          wl_q    <= wl_d;
          we_q    <= rw_q;
          re_q    <= ~rw_q;
          cnt_q   <= PULSE_LAST;
          state_q <= PULSE;
        end

        PULSE: begin
          if (cnt_q == '0) begin
            wl_q    <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            cnt_q   <= RECOV_LAST;
            // With a one-cycle recovery the first RECOVER cycle is also
            // the last, so done is raised on entry.
            done_q  <= (RECOV_CYC == 1);
            state_q <= RECOVER;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        RECOVER: begin
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q  <= cnt_q - 4'd1;
            // Counter reaches zero in the next cycle, which is the last
            // RECOVER cycle.
            done_q <= (cnt_q == 4'd1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign wl   = wl_q;
  assign we   = we_q;
  assign re   = re_q;
  assign done = done_q;
  assign ovr  = ovr_q;

  // ---------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------
  a_wl_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(wl_q));
  a_strobe_excl : assert property (@(posedge clk) disable iff (rst) !(we_q && re_q));
  a_wl_pulse_only : assert property (@(posedge clk) disable iff (rst)
                                     (wl_q != '0) |-> (state_q == PULSE));

endmodule

// File: tb/tb_wordline_decoder_ctrl.sv
// Bench for wordline_decoder_ctrl. Two instances run side by side: u0 with
// default parameters (ADDR_W=3, PULSE_CYC=2, RECOV_CYC=1) and u1 with
// ADDR_W=4, PULSE_CYC=3, RECOV_CYC=2. The driver pushes one expected access
// per accepted request; the monitor pops it when busy rises and checks every
// busy cycle against the access timeline (SETUP, PULSE_CYC pulse cycles,
// RECOV_CYC recovery cycles with done in the last).

module tb_wordline_decoder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_v [2];
  logic [3:0] adr_v [2];
  logic       rw_v  [2];
  logic       busy_v[2];
  logic       we_v  [2];
  logic       re_v  [2];
  logic       done_v[2];
  logic       ovr_v [2];
  logic [7:0]  wl0;
  logic [15:0] wl1;

  wordline_decoder_ctrl u0 (
    .clk (clk),
    .rst (rst),
    .req (req_v[0]),
    .adr (adr_v[0][2:0]),
    .rw  (rw_v[0]),
    .busy(busy_v[0]),
    .wl  (wl0),
    .we  (we_v[0]),
    .re  (re_v[0]),
    .done(done_v[0]),
    .ovr (ovr_v[0])
  );

  wordline_decoder_ctrl #(
    .ADDR_W   (4),
    .PULSE_CYC(3),
    .RECOV_CYC(2)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .req (req_v[1]),
    .adr (adr_v[1]),
    .rw  (rw_v[1]),
    .busy(busy_v[1]),
    .wl  (wl1),
    .we  (we_v[1]),
    .re  (re_v[1]),
    .done(done_v[1]),
    .ovr (ovr_v[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pc(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int rc(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  typedef struct {
    logic [15:0] wl;
    logic        rw;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];
  int   bcnt[2];
  bit   active[2];
  bit   ovr_exp[2];

  // ---------------------------------------------------------------------
  // Monitor: samples on the falling edge, away from the active edge
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [15:0] wl;
      logic [19:0] act;
      logic [19:0] expv;
      logic        inp;
      int          p;
      int          r;
      int          qs;
      bit          ended;
      if (rst) begin
        active[d] = 1'b0;
        bcnt[d]   = 0;
        if (d == 0) q0.delete(); else q1.delete();
      end else begin
        wl    = (d == 0) ? {8'h00, wl0} : wl1;
        p     = pc(d);
        r     = rc(d);
        ended = 1'b0;
        act   = {busy_v[d], wl, we_v[d], re_v[d], done_v[d]};
        if (busy_v[d] && !active[d]) begin
          qs = (d == 0) ? q0.size() : q1.size();
          chk($sformatf("accept_has_expected_u%0d", d), 32'(qs != 0), 32'd1);
          if (qs != 0) begin
            if (d == 0) cur[d] = q0.pop_front(); else cur[d] = q1.pop_front();
            active[d] = 1'b1;
            bcnt[d]   = 0;
          end
        end
        if (active[d]) begin
          if (bcnt[d] == 1 + p + r) begin
            chk($sformatf("end_idle_u%0d", d), 32'(act), 32'd0);
            active[d] = 1'b0;
            ended     = 1'b1;
          end else begin
            inp  = (bcnt[d] >= 1) && (bcnt[d] <= p);
            expv = {1'b1,
                    inp ? cur[d].wl : 16'h0000,
                    inp & cur[d].rw,
                    inp & ~cur[d].rw,
                    (bcnt[d] == p + r) ? 1'b1 : 1'b0};
            chk($sformatf("cycle%0d_u%0d", bcnt[d], d), 32'(act), 32'(expv));
            bcnt[d]++;
          end
        end else if (!ended) begin
          chk($sformatf("idle_u%0d", d), 32'(act), 32'd0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------
  // Issues one accepted request, then drives the busy window: adr/rw are
  // scrambled every cycle (alt at the SETUP cycle), and an overrun request
  // is raised at busy cycle inj_at when inj_at >= 0. Returns at the first
  // IDLE cycle, where the next request may be issued.
  task automatic access(input int d, input logic [3:0] a, input logic rw,
                        input int inj_at, input logic [3:0] alt);
    exp_t e;
    e.wl = 16'h0001 << a;
    e.rw = rw;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    req_v[d] = 1'b1;
    adr_v[d] = a;
    rw_v[d]  = rw;
    @(negedge clk);
    for (int m = 0; m <= pc(d) + rc(d); m++) begin
      adr_v[d] = (m == 0 || m == inj_at) ? alt : 4'($urandom);
      rw_v[d]  = 1'($urandom);
      if (m == inj_at) begin
        req_v[d]   = 1'b1;
        ovr_exp[d] = 1'b1;
      end else begin
        req_v[d] = 1'b0;
      end
      @(negedge clk);
    end
    req_v[d] = 1'b0;
    chk($sformatf("ovr_u%0d", d), 32'(ovr_v[d]), 32'(ovr_exp[d]));
  endtask

  // Asserts rst between clock edges and checks the outputs drop at once.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_u0", 32'({busy_v[0], wl0, we_v[0], re_v[0], done_v[0], ovr_v[0]}), 32'd0);
    chk("rst_out_u1", 32'({busy_v[1], wl1, we_v[1], re_v[1], done_v[1], ovr_v[1]}), 32'd0);
    ovr_exp[0] = 1'b0;
    ovr_exp[1] = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_v[d]   = 1'b0;
      adr_v[d]   = '0;
      rw_v[d]    = 1'b0;
      ovr_exp[d] = 1'b0;
      active[d]  = 1'b0;
      bcnt[d]    = 0;
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_u0", 32'({busy_v[0], wl0, we_v[0], re_v[0], done_v[0], ovr_v[0]}), 32'd0);
    chk("reset_u1", 32'({busy_v[1], wl1, we_v[1], re_v[1], done_v[1], ovr_v[1]}), 32'd0);
    #2;
    rst = 1'b0;
    @(negedge clk);

    // Default write to row 5.
    access(0, 4'd5, 1'b1, -1, 4'd5);

    // Read sweep over every row, back to back.
    for (int a = 0; a < 8; a++) begin
      access(0, 4'(a), 1'b0, -1, 4'(a));
    end

    // Overrun during PULSE with a different address; flag stays sticky.
    access(0, 4'd2, 1'b0, 1, 4'd6);
    access(0, 4'd4, 1'b1, -1, 4'd4);
    access(0, 4'd7, 1'b0, -1, 4'd7);
    do_reset();
    chk("ovr_cleared_u0", 32'(ovr_v[0]), 32'd0);

    // Reset in the middle of PULSE, then a normal access.
    q0.push_back('{wl: 16'h0008, rw: 1'b1});
    req_v[0] = 1'b1;
    adr_v[0] = 4'd3;
    rw_v[0]  = 1'b1;
    @(negedge clk);
    req_v[0] = 1'b0;
    @(negedge clk);
    do_reset();
    access(0, 4'd1, 1'b0, -1, 4'd1);

    // Address changed during SETUP must not move the pulse.
    access(0, 4'd3, 1'b1, -1, 4'd7);

    // Wide instance: top row, 3-cycle pulse, 2-cycle recovery.
    access(1, 4'd15, 1'b1, -1, 4'd0);

    // Overrun in the final recovery cycle of each instance.
    access(0, 4'd6, 1'b0, pc(0) + rc(0), 4'd1);
    access(1, 4'd9, 1'b0, pc(1) + rc(1), 4'd2);
    do_reset();

    // Randomized accesses with random gaps and occasional overruns.
    for (int i = 0; i < 60; i++) begin
      int d;
      int inj;
      logic [3:0] a;
      d   = $urandom_range(0, 1);
      a   = (d == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(0, pc(d) + rc(d)) : -1;
      access(d, a, 1'($urandom), inj, 4'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("drain", 32'(q0.size() + q1.size() + int'(active[0]) + int'(active[1])), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
